// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register map,
// vector constants, FSM states, source indices and a helper that
// tells whether the source behind a latched vector is still pending.
package interrupt_controller_pkg;

    localparam int NUM_SRC = 6;

    // Factor registers (read-clear, not writable)
    localparam logic [11:0] ADDR_F_CT  = 12'hF00;
    localparam logic [11:0] ADDR_F_SW  = 12'hF01;
    localparam logic [11:0] ADDR_F_PT  = 12'hF02;
    localparam logic [11:0] ADDR_F_SER = 12'hF03;
    localparam logic [11:0] ADDR_F_K00 = 12'hF04;
    localparam logic [11:0] ADDR_F_K10 = 12'hF05;
    // Mask registers (read/write)
    localparam logic [11:0] ADDR_M_CT  = 12'hF10;
    localparam logic [11:0] ADDR_M_SW  = 12'hF11;
    localparam logic [11:0] ADDR_M_PT  = 12'hF12;
    localparam logic [11:0] ADDR_M_SER = 12'hF13;
    localparam logic [11:0] ADDR_M_K00 = 12'hF14;
    localparam logic [11:0] ADDR_M_K10 = 12'hF15;

    localparam logic [3:0] VEC_PT  = 4'hC;
    localparam logic [3:0] VEC_SER = 4'hA;
    localparam logic [3:0] VEC_K00 = 4'h8;
    localparam logic [3:0] VEC_K10 = 4'h6;
    localparam logic [3:0] VEC_SW  = 4'h4;
    localparam logic [3:0] VEC_CT  = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_HOLDOFF
    } state_e;

    typedef enum logic [2:0] {
        SRC_CT  = 3'd0,
        SRC_SW  = 3'd1,
        SRC_PT  = 3'd2,
        SRC_SER = 3'd3,
        SRC_K00 = 3'd4,
        SRC_K10 = 3'd5
    } src_e;

    // Pending state of the source that owns a given vector.
    function automatic logic vec_pending(input logic [NUM_SRC-1:0] pend,
                                         input logic [3:0]         vec);
        case (vec)
            VEC_PT:  return pend[SRC_PT];
            VEC_SER: return pend[SRC_SER];
            VEC_K00: return pend[SRC_K00];
            VEC_K10: return pend[SRC_K10];
            VEC_SW:  return pend[SRC_SW];
            VEC_CT:  return pend[SRC_CT];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder over the six interrupt sources.
// Ports: pending (one bit per src_e index) in; valid and vector out.
// Order, highest first: prog timer, serial, K00, K10, stopwatch, clock timer.
module interrupt_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_SRC-1:0] pending,
    output logic               valid,
    output logic [3:0]         vector
);

    always_comb begin
        valid  = |pending;
        vector = 4'h0;
        if      (pending[SRC_PT])  vector = VEC_PT;
        else if (pending[SRC_SER]) vector = VEC_SER;
        else if (pending[SRC_K00]) vector = VEC_K00;
        else if (pending[SRC_K10]) vector = VEC_K10;
        else if (pending[SRC_SW])  vector = VEC_SW;
        else if (pending[SRC_CT])  vector = VEC_CT;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: factor (read-clear) and mask registers on the
// CPU data bus, a priority encoder, and an IDLE/REQUEST/HOLDOFF FSM
// driving irq/irq_vector to the core.
// Ports: clk, reset_n (async low); *_set factor-set pulses; bus_addr,
// bus_read, bus_write, bus_wdata, bus_rdata, bus_hit; cpu_ie; irq,
// irq_vector, irq_ack.
module interrupt_controller #(
    parameter int ACK_HOLDOFF = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  clock_timer_set,
    input  logic [1:0]  stopwatch_set,
    input  logic        prog_timer_set,
    input  logic        serial_set,
    input  logic        k00_set,
    input  logic        k10_set,
    input  logic [11:0] bus_addr,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [3:0]  bus_wdata,
    output logic [3:0]  bus_rdata,
    output logic        bus_hit,
    input  logic        cpu_ie,
    output logic        irq,
    output logic [3:0]  irq_vector,
    input  logic        irq_ack
);
    import interrupt_controller_pkg::*;

    logic [3:0] ct_f, ct_m;
    logic [1:0] sw_f, sw_m;
    logic       pt_f, pt_m, ser_f, ser_m, k00_f, k00_m, k10_f, k10_m;

    logic [NUM_SRC-1:0] pend;
    logic               enc_valid;
    logic [3:0]         enc_vector;
    state_e             state;
    logic [1:0]         hold_cnt;

    function automatic logic rd_hit(input logic [11:0] a);
        return bus_read && (bus_addr == a);
    endfunction

    // Factor bits: read clears the whole register, a set pulse in the
    // same cycle still lands (OR after the clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ct_f  <= '0;
            sw_f  <= '0;
            pt_f  <= 1'b0;
            ser_f <= 1'b0;
            k00_f <= 1'b0;
            k10_f <= 1'b0;
        end else begin
            ct_f  <= (rd_hit(ADDR_F_CT)  ? 4'b0 : ct_f)  | clock_timer_set;
            sw_f  <= (rd_hit(ADDR_F_SW)  ? 2'b0 : sw_f)  | stopwatch_set;
            pt_f  <= (rd_hit(ADDR_F_PT)  ? 1'b0 : pt_f)  | prog_timer_set;
            ser_f <= (rd_hit(ADDR_F_SER) ? 1'b0 : ser_f) | serial_set;
            k00_f <= (rd_hit(ADDR_F_K00) ? 1'b0 : k00_f) | k00_set;
            k10_f <= (rd_hit(ADDR_F_K10) ? 1'b0 : k10_f) | k10_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ct_m  <= '0;
            sw_m  <= '0;
            pt_m  <= 1'b0;
            ser_m <= 1'b0;
            k00_m <= 1'b0;
            k10_m <= 1'b0;
        end else if (bus_write) begin
            case (bus_addr)
                ADDR_M_CT:  ct_m  <= bus_wdata;
                ADDR_M_SW:  sw_m  <= bus_wdata[1:0];
                ADDR_M_PT:  pt_m  <= bus_wdata[0];
                ADDR_M_SER: ser_m <= bus_wdata[0];
                ADDR_M_K00: k00_m <= bus_wdata[0];
                ADDR_M_K10: k10_m <= bus_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_rdata = 4'h0;
        case (bus_addr)
            ADDR_F_CT:  bus_rdata = ct_f;
            ADDR_F_SW:  bus_rdata = {2'b0, sw_f};
            ADDR_F_PT:  bus_rdata = {3'b0, pt_f};
            ADDR_F_SER: bus_rdata = {3'b0, ser_f};
            ADDR_F_K00: bus_rdata = {3'b0, k00_f};
            ADDR_F_K10: bus_rdata = {3'b0, k10_f};
            ADDR_M_CT:  bus_rdata = ct_m;
            ADDR_M_SW:  bus_rdata = {2'b0, sw_m};
            ADDR_M_PT:  bus_rdata = {3'b0, pt_m};
            ADDR_M_SER: bus_rdata = {3'b0, ser_m};
            ADDR_M_K00: bus_rdata = {3'b0, k00_m};
            ADDR_M_K10: bus_rdata = {3'b0, k10_m};
            default: ;
        endcase
    end

    assign bus_hit = ((bus_addr >= ADDR_F_CT) && (bus_addr <= ADDR_F_K10)) ||
                     ((bus_addr >= ADDR_M_CT) && (bus_addr <= ADDR_M_K10));

    assign pend[SRC_CT]  = |(ct_f & ct_m);
    assign pend[SRC_SW]  = |(sw_f & sw_m);
    assign pend[SRC_PT]  = pt_f  & pt_m;
    assign pend[SRC_SER] = ser_f & ser_m;
    assign pend[SRC_K00] = k00_f & k00_m;
    assign pend[SRC_K10] = k10_f & k10_m;

    interrupt_priority_encoder u_enc (
        .pending (pend),
        .valid   (enc_valid),
        .vector  (enc_vector)
    );

    // irq_vector is frozen while in REQUEST; the latched vector also
    // identifies which source must stay pending to keep the request up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            irq_vector <= 4'h0;
            hold_cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_ie && enc_valid) begin
                        state      <= ST_REQUEST;
                        irq        <= 1'b1;
                        irq_vector <= enc_vector;
                    end
                end
                ST_REQUEST: begin
                    if (irq_ack) begin
                        irq <= 1'b0;
                        if (ACK_HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_HOLDOFF;
                            hold_cnt <= 2'(ACK_HOLDOFF - 1);
                        end
                    end else if (!cpu_ie || !vec_pending(pend, irq_vector)) begin
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == 2'd0) state <= ST_IDLE;
                    else                  hold_cnt <= hold_cnt - 2'd1;
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule
